magnitude_tracker: RTL and testbench

MAGNITUDE_TRACKER -- requirements
Module: magnitude_tracker

---
 rtl/mag_track_pkg.sv | 12 +
 rtl/mag_track_cmp4.sv | 19 +
 rtl/magnitude_tracker.sv | 134 +++++++++++++
 tb/tb_magnitude_tracker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mag_track_pkg.sv
// Shared definitions for the magnitude tracker: FSM state encoding and sample width.
package mag_track_pkg;

  localparam int SAMPLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/mag_track_cmp4.sv
// Combinational unsigned magnitude comparator: a against b.
module mag_cmp4
  import mag_track_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  output logic                gt,
  output logic                lt,
  output logic                eq
);

  // Exactly one of the three flags is high for any pair of operands.
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/magnitude_tracker.sv
// Frame magnitude tracker: per frame of 4-bit unsigned samples, reports max, min
// and counts of rising/falling/flat steps between consecutive samples.
// Optional build macro MAG_TRACK_SAT_EN: counters saturate at all-ones instead of wrapping.
module magnitude_tracker
  import mag_track_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_max,
  output logic [SAMPLE_W-1:0] out_min,
  output logic [CNT_W-1:0]    out_gt_cnt,
  output logic [CNT_W-1:0]    out_lt_cnt,
  output logic [CNT_W-1:0]    out_eq_cnt
);

  state_t              state;
  logic [SAMPLE_W-1:0] prev;
  logic [SAMPLE_W-1:0] max_val;
  logic [SAMPLE_W-1:0] min_val;
  logic [CNT_W-1:0]    gt_cnt;
  logic [CNT_W-1:0]    lt_cnt;
  logic [CNT_W-1:0]    eq_cnt;

  logic accept;
  logic prev_gt, prev_lt, prev_eq;
  logic max_gt, max_lt, max_eq;
  logic min_gt, min_lt, min_eq;
  logic cmp_unused;

  // Step counter increment; wraps by default, sticks at all-ones when saturation is built in.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef MAG_TRACK_SAT_EN
    bump = (&c) ? c : c + CNT_W'(1);
`else
    bump = c + CNT_W'(1);
`endif
  endfunction

  // Step direction relative to the previous sample of the frame.
  mag_cmp4 u_cmp_prev (
    .a  (in_data),
    .b  (prev),
    .gt (prev_gt),
    .lt (prev_lt),
    .eq (prev_eq)
  );

  // Extremes update: the bound comparison is a pair, one side against max, one against min.
  mag_cmp4 u_cmp_max (
    .a  (in_data),
    .b  (max_val),
    .gt (max_gt),
    .lt (max_lt),
    .eq (max_eq)
  );

  mag_cmp4 u_cmp_min (
    .a  (in_data),
    .b  (min_val),
    .gt (min_gt),
    .lt (min_lt),
    .eq (min_eq)
  );

  // Only the relevant side of each bound comparison is used.
  assign cmp_unused = ^{max_lt, max_eq, min_gt, min_eq};

  // Handshake: input open while no summary is pending; summary visible only in REPORT.
  always_comb begin
    in_ready  = (state != REPORT);
    out_valid = (state == REPORT);
    accept    = in_valid && in_ready;
  end

  // Summary fields come straight from the tracking registers.
  always_comb begin
    out_max    = max_val;
    out_min    = min_val;
    out_gt_cnt = gt_cnt;
    out_lt_cnt = lt_cnt;
    out_eq_cnt = eq_cnt;
  end

  // Frame FSM and tracking state; reset discards any open or reported frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= '0;
      max_val <= '0;
      min_val <= '0;
      gt_cnt  <= '0;
      lt_cnt  <= '0;
      eq_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            prev    <= in_data;
            max_val <= in_data;
            min_val <= in_data;
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            state   <= in_last ? REPORT : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (prev_gt) gt_cnt <= bump(gt_cnt);
            if (prev_lt) lt_cnt <= bump(lt_cnt);
            if (prev_eq) eq_cnt <= bump(eq_cnt);
            if (max_gt)  max_val <= in_data;
            if (min_lt)  min_val <= in_data;
            prev  <= in_data;
            state <= in_last ? REPORT : RUN;
          end
        end
        REPORT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_tracker.sv
// Self-checking bench for magnitude_tracker: table of frames, random frames with a
// reference model, and hand sequences for back-pressure, reset abort and valid gaps.
module tb_magnitude_tracker;

  localparam int CNT_W = 2;
`ifdef MAG_TRACK_SAT_EN
  localparam int EQ_SIX = 3;
`else
  localparam int EQ_SIX = 1;
`endif

  typedef struct packed {
    logic [3:0]       mx;
    logic [3:0]       mn;
    logic [CNT_W-1:0] gt;
    logic [CNT_W-1:0] lt;
    logic [CNT_W-1:0] eq;
  } sum_t;

  typedef struct {
    int         len;
    logic [3:0] s [8];
    bit         gap;
    sum_t       exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_max;
  logic [3:0]       out_min;
  logic [CNT_W-1:0] out_gt_cnt;
  logic [CNT_W-1:0] out_lt_cnt;
  logic [CNT_W-1:0] out_eq_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  sum_t exp_q[$];
  logic lat_pend = 1'b0;
  vec_t tbl [6];

  magnitude_tracker #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_max    (out_max),
    .out_min    (out_min),
    .out_gt_cnt (out_gt_cnt),
    .out_lt_cnt (out_lt_cnt),
    .out_eq_cnt (out_eq_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
`ifdef MAG_TRACK_SAT_EN
    if (c == {CNT_W{1'b1}}) return c;
`endif
    return c + 1'b1;
  endfunction

  function automatic sum_t model(input int len, input logic [3:0] s [8]);
    sum_t r;
    r.mx = s[0]; r.mn = s[0]; r.gt = '0; r.lt = '0; r.eq = '0;
    for (int i = 1; i < len; i++) begin
      if (s[i] > s[i-1]) r.gt = inc(r.gt);
      else if (s[i] < s[i-1]) r.lt = inc(r.lt);
      else r.eq = inc(r.eq);
      if (s[i] > r.mx) r.mx = s[i];
      if (s[i] < r.mn) r.mn = s[i];
    end
    return r;
  endfunction

  // Drive one sample and hold it until the DUT takes it (bounded wait).
  task automatic send(input logic [3:0] d, input logic l);
    int k;
    in_valid = 1'b1; in_data = d; in_last = l;
    k = 0;
    while (!in_ready && k < 64) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    exp_q.push_back(v.exp);
    for (int i = 0; i < v.len; i++) begin
      send(v.s[i], (i == v.len - 1));
      if (v.gap) begin @(posedge clk); #1; end
    end
  endtask

  // Scoreboard and latency monitor, sampled on the falling edge.
  always @(negedge clk) begin
    sum_t got;
    if (rst_n) begin
      if (lat_pend) chk("latency_out_valid", int'(out_valid), 1);
      lat_pend <= in_valid && in_ready && in_last;
      if (out_valid) begin
        got = '{out_max, out_min, out_gt_cnt, out_lt_cnt, out_eq_cnt};
        if (exp_q.size() == 0) begin
          chk("unexpected_summary", 1, 0);
        end else begin
          n_tests++;
          if (got !== exp_q[0]) begin
            n_fail++;
            $display("FAIL summary: got max=%0d min=%0d gt=%0d lt=%0d eq=%0d, expected max=%0d min=%0d gt=%0d lt=%0d eq=%0d",
                     got.mx, got.mn, got.gt, got.lt, got.eq,
                     exp_q[0].mx, exp_q[0].mn, exp_q[0].gt, exp_q[0].lt, exp_q[0].eq);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end else begin
      lat_pend <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{8, '{4'd2, 4'd11, 4'd11, 4'd12, 4'd9, 4'd3, 4'd6, 4'd2}, 1'b0, '{4'd12, 4'd2, 2'd3, 2'd3, 2'd1}};
    tbl[1] = '{1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, '{4'd7, 4'd7, 2'd0, 2'd0, 2'd0}};
    tbl[2] = '{6, '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0}, 1'b0, '{4'd5, 4'd5, 2'd0, 2'd0, CNT_W'(EQ_SIX)}};
    tbl[3] = '{3, '{4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, '{4'd15, 4'd0, 2'd1, 2'd1, 2'd0}};
    tbl[4] = '{4, '{4'd15, 4'd14, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0, '{4'd15, 4'd0, 2'd0, 2'd3, 2'd0}};
    tbl[5] = '{2, '{4'd3, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b1, '{4'd8, 4'd3, 2'd1, 2'd0, 2'd0}};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_max", int'(out_max), 0);
    chk("reset_min", int'(out_min), 0);
    chk("reset_counts", int'({out_gt_cnt, out_lt_cnt, out_eq_cnt}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i]);
      @(posedge clk); #1;
    end

    // Random frames checked against the reference model.
    for (int f = 0; f < 6; f++) begin
      v.len = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) v.s[i] = 4'($urandom_range(0, 15));
      v.gap = 1'b0;
      v.exp = model(v.len, v.s);
      run_frame(v);
    end
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: summary held, pending sample not consumed.
    out_ready = 1'b0;
    exp_q.push_back('{4'd10, 4'd4, 2'd1, 2'd0, 2'd0});
    send(4'd4, 1'b0);
    send(4'd10, 1'b1);
    in_valid = 1'b1; in_data = 4'd15; in_last = 1'b1;
    exp_q.push_back('{4'd15, 4'd15, 2'd0, 2'd0, 2'd0});
    for (int c = 0; c < 3; c++) begin
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame.
    send(4'd4, 1'b0);
    send(4'd9, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    exp_q.push_back('{4'd1, 4'd1, 2'd0, 2'd0, 2'd1});
    send(4'd1, 1'b0);
    send(4'd1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
